// File: rtl/ours_output_ppln.sv
// Registered egress stage for valid/ready streams: 2-entry skid buffer (main + skid) under a 3-state FSM.
// Optional statistics counters are compiled in with `define OURS_OUTPUT_PPLN_STATS_EN.
module ours_output_ppln #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out
`ifdef OURS_OUTPUT_PPLN_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_valid_out;
    logic             r_ready_out;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_push;
    logic w_pop;
    logic w_load_main;
    logic w_main_from_skid;
    logic w_load_skid;

    assign w_push    = valid_in & r_ready_out;
    assign w_pop     = r_valid_out & ready_in;
    assign valid_out = r_valid_out;
    assign ready_out = r_ready_out;
    assign data_out  = r_main;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= EMPTY;
            r_valid_out <= 1'b0;
            r_ready_out <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_valid_out <= (w_next_state != EMPTY);
            r_ready_out <= (w_next_state != FULL);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_load_main  = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (w_push && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_push) begin
                    w_load_skid  = 1'b1;
                    w_next_state = FULL;
                end else if (w_pop) begin
                    w_next_state = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_next_state     = BUSY;
                end
            end
            default: w_next_state = EMPTY;
        endcase
        // Flush discards everything in flight, including a coincident push.
        if (flush) begin
            w_next_state = EMPTY;
            w_load_main  = 1'b0;
            w_load_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_main) begin
            r_main <= w_main_from_skid ? r_skid : data_in;
        end
        if (w_load_skid) begin
            r_skid <= data_in;
        end
    end

`ifdef OURS_OUTPUT_PPLN_STATS_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_xfer_cnt;

    // Stall count saturates; transfer count wraps. Neither is cleared by flush.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            if (r_valid_out && !ready_in && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign xfer_cnt  = r_xfer_cnt;
`else
    a_cnt_width: assert property (@(posedge clk) CNT_WIDTH > 0);
`endif

    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
        !(w_push && (r_state == FULL)));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
        (r_valid_out && !ready_in && !flush) |=> ($stable(r_main) && r_valid_out));

endmodule

// File: tb/tb_ours_output_ppln.sv
// Scoreboard bench for ours_output_ppln: stimulus queues accepted payloads, a negedge monitor checks each pop.
module tb_ours_output_ppln;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             flush;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] data_in;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;
`ifdef OURS_OUTPUT_PPLN_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] xfer_cnt;
`endif

    ours_output_ppln #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out)
`ifdef OURS_OUTPUT_PPLN_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int               total_cnt = 0;
    int               pass_cnt  = 0;
    logic [WIDTH-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every pop is compared against the oldest queued push.
    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            sb.delete();
        end else begin
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL pop_unexpected got=%0h expected=none", data_out);
                end else begin
                    logic [WIDTH-1:0] exp_d;
                    exp_d = sb.pop_front();
                    chk("pop_data", data_out, exp_d);
                    $display("pop data=%0h", data_out);
                end
            end
            if (flush) sb.delete();
        end
    end

    // Drive one cycle of inputs (called at posedge+1), record an accepted push, return at next posedge+1.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f,
                        output logic acc);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush    = f;
        #2;
        acc = rstn && v && ready_out && !f;
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    logic             acc;
    logic             rv;
    logic             pending;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] nxt;

    initial begin
        rstn     = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        @(posedge clk);
        #1;

        // Reset held three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, acc);
            chk("reset_valid", valid_out, 0);
            chk("reset_ready", ready_out, 0);
        end
        rstn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("release_ready", ready_out, 1);
        chk("release_valid", valid_out, 0);

        // Streaming at full rate.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, acc);
            chk("stream_acc", acc, 1);
            chk("stream_ready", ready_out, 1);
            chk("stream_valid", valid_out, 1);
            chk("stream_data", data_out, i);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("stream_drain", sb.size(), 0);
        chk("stream_empty", valid_out, 0);

        // Backpressure: fill main then skid.
        step(1'b1, 8'hA1, 1'b0, 1'b0, acc);
        chk("bp_busy_valid", valid_out, 1);
        chk("bp_busy_ready", ready_out, 1);
        step(1'b1, 8'hA2, 1'b0, 1'b0, acc);
        chk("bp_full_ready", ready_out, 0);
        chk("bp_full_data", data_out, 8'hA1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, acc);
            chk("bp_hold_valid", valid_out, 1);
            chk("bp_hold_data", data_out, 8'hA1);
            chk("bp_hold_ready", ready_out, 0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("bp_pop1_ready", ready_out, 1);
        chk("bp_pop1_data", data_out, 8'hA2);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("bp_pop2_valid", valid_out, 0);
        chk("bp_drain", sb.size(), 0);

        // Flush while FULL, with a concurrent push that must be lost.
        step(1'b1, 8'h55, 1'b0, 1'b0, acc);
        step(1'b1, 8'h66, 1'b0, 1'b0, acc);
        chk("fl_full_ready", ready_out, 0);
        step(1'b1, 8'h77, 1'b0, 1'b1, acc);
        chk("fl_valid", valid_out, 0);
        chk("fl_ready", ready_out, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, acc);
            chk("fl_idle_valid", valid_out, 0);
        end

        // Random valid/ready traffic; upstream holds data until accepted.
        nxt     = 8'h00;
        pending = 1'b0;
        rv      = 1'b0;
        rd      = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            if (!pending) begin
                rv = ($urandom_range(0, 3) != 0);
                rd = nxt;
            end
            step(rv, rd, ($urandom_range(0, 2) != 0), 1'b0, acc);
            if (acc) nxt = nxt + 1'b1;
            pending = rv && !acc;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("rand_drain", sb.size(), 0);
        chk("rand_empty", valid_out, 0);

`ifdef OURS_OUTPUT_PPLN_STATS_EN
        // Counters: saturating stall count, wrapping transfer count.
        rstn = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        rstn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("st_stall_rst", stall_cnt, 0);
        chk("st_xfer_rst", xfer_cnt, 0);
        step(1'b1, 8'hC0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("st_stall_sat", stall_cnt, 15);
        chk("st_xfer_zero", xfer_cnt, 0);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("st_xfer_wrap", xfer_cnt, 2);
        chk("st_stall_hold", stall_cnt, 15);
        chk("st_drain", sb.size(), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
